// File: rtl/sdram_write_scheduler.sv
// Drains whole packets from the usb_to_sdram read port and writes each as one
// SDRAM burst into a circular buffer, dropping packets when the ring is full.
module sdram_write_scheduler #(
    parameter int ADDR_W    = 24,
    parameter int PKT_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [15:0]       fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_pull,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [15:0]       mem_wr_data,
    input  logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              overflow,
    output logic [15:0]       drop_count,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = $clog2(PKT_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        DATA    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   word_cnt;
    logic [ADDR_W-1:0]  free_words;
    logic               last_word;

    // One slot is kept empty so that equal pointers always mean an empty ring.
    assign free_words = rd_ptr - wr_ptr - ADDR_W'(1);
    assign last_word  = (word_cnt == CNT_W'(PKT_WORDS - 1));
    assign busy       = (state != IDLE);
    assign state_dbg  = state;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid and its payload are held stable until that edge.
    always_comb begin
        state_next    = state;
        fifo_pull     = 1'b0;
        mem_cmd_valid = 1'b0;
        mem_cmd_addr  = '0;
        mem_wr_valid  = 1'b0;
        mem_wr_data   = '0;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    if (free_words >= ADDR_W'(PKT_WORDS)) state_next = CMD;
                    else                                  state_next = DISCARD;
                end
            end
            CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_addr  = wr_ptr;
                if (mem_cmd_ready) state_next = DATA;
            end
            DATA: begin
                mem_wr_valid = !fifo_empty;
                mem_wr_data  = fifo_data;
                fifo_pull    = mem_wr_valid && mem_wr_ready;
                if (fifo_pull && last_word) state_next = IDLE;
            end
            DISCARD: begin
                fifo_pull = !fifo_empty;
                if (fifo_pull && last_word) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            word_cnt   <= '0;
            wr_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE)  word_cnt <= '0;
            else if (fifo_pull) word_cnt <= word_cnt + CNT_W'(1);
            if (state == DATA && fifo_pull && last_word)
                wr_ptr <= wr_ptr + ADDR_W'(PKT_WORDS);
            if (state == DISCARD && fifo_pull && last_word) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_write_scheduler.sv
// Directed bench for sdram_write_scheduler on an 8-bit ring: a packet FIFO
// model feeds the DUT and a negedge monitor records every handshake.
module tb_sdram_write_scheduler;

    localparam int ADDR_W = 8;
    localparam int PKT    = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b1;
    logic [15:0]       fifo_data;
    logic              fifo_empty;
    logic              fifo_pull;
    logic              mem_cmd_valid;
    logic              mem_cmd_ready = 1'b1;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic              mem_wr_valid;
    logic              mem_wr_ready = 1'b1;
    logic [15:0]       mem_wr_data;
    logic [ADDR_W-1:0] rd_ptr = '0;
    logic [ADDR_W-1:0] wr_ptr;
    logic              overflow;
    logic [15:0]       drop_count;
    logic              busy;
    logic [1:0]        state_dbg;

    sdram_write_scheduler #(.ADDR_W(ADDR_W), .PKT_WORDS(PKT)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_pull(fifo_pull),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_addr(mem_cmd_addr), .mem_wr_valid(mem_wr_valid),
        .mem_wr_ready(mem_wr_ready), .mem_wr_data(mem_wr_data),
        .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .overflow(overflow),
        .drop_count(drop_count), .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic [15:0] fmem [0:1023];
    int head = 0;
    int tail = 0;
    logic pull_d = 1'b0;

    assign fifo_empty = (head == tail);
    assign fifo_data  = fmem[head % 1024];

    always @(posedge clk) if (pull_d) head <= head + 1;

    // ---------------- monitor / scoreboard queues ----------------
    logic [ADDR_W-1:0] got_addr[$];
    logic [15:0]       got_data[$];
    logic [15:0]       exp_q[$];
    int n_pull = 0, bad_pull = 0, stall = 0, mem_act = 0;

    always @(negedge clk) begin
        pull_d = fifo_pull;
        if (fifo_pull) n_pull++;
        if (fifo_pull && !mem_wr_ready && state_dbg == 2'd2) bad_pull++;
        if (mem_cmd_valid && mem_cmd_ready) got_addr.push_back(mem_cmd_addr);
        if (mem_cmd_valid && !mem_cmd_ready) stall++;
        if (mem_wr_valid && mem_wr_ready) got_data.push_back(mem_wr_data);
        if (mem_cmd_valid || mem_wr_valid) mem_act++;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Bytes 2i+s and 2i+1+s form word i, low byte first.
    task automatic push_pkt(input int s);
        logic [7:0] lo, hi;
        for (int i = 0; i < PKT; i++) begin
            lo = 8'(2 * i + s);
            hi = 8'(2 * i + 1 + s);
            fmem[(tail + i) % 1024] = {hi, lo};
        end
        tail = tail + PKT;
    endtask

    task automatic queue_expected(input int s);
        logic [7:0] lo, hi;
        for (int i = 0; i < PKT; i++) begin
            lo = 8'(2 * i + s);
            hi = 8'(2 * i + 1 + s);
            exp_q.push_back({hi, lo});
        end
    endtask

    // Runs until busy falls (or rst is applied at word rst_at); returns cycles.
    task automatic run_packet(input int cmd_delay, input bit toggle, input int en_drop_at,
                              input int rst_at, output int cycles);
        int p0;
        bit seen, done;
        p0 = n_pull;
        seen = 0;
        done = 0;
        cycles = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            mem_cmd_ready = (k > cmd_delay);
            mem_wr_ready  = toggle ? (k % 2 == 1) : 1'b1;
            if (en_drop_at >= 0 && n_pull - p0 >= en_drop_at) enable = 1'b0;
            if (rst_at >= 0 && n_pull - p0 >= rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (busy) seen = 1;
            else if (seen) done = 1;
        end
        mem_cmd_ready = 1'b1;
        mem_wr_ready  = 1'b1;
        check("packet_completes", {31'd0, done}, 32'd1);
    endtask

    task automatic check_data(input string tag, input int d0);
        check({tag, "_count"}, got_data.size() - d0, PKT);
        for (int i = 0; i < PKT; i++)
            if (d0 + i < got_data.size() && exp_q.size() > 0)
                check(tag, got_data[d0 + i], exp_q.pop_front());
        exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int cyc, p0, a0, d0, m0;
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_wr_ptr", wr_ptr, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop", drop_count, 0);
        check("rst_cmd_valid", mem_cmd_valid, 0);
        check("rst_pull", fifo_pull, 0);

        // Single packet, full-rate handshakes
        p0 = n_pull; d0 = got_data.size();
        push_pkt(0); queue_expected(0);
        run_packet(0, 0, -1, -1, cyc);
        check("single_cycles", cyc, 66);
        check("single_addr", got_addr[0], 0);
        check("single_wr_ptr", wr_ptr, 64);
        check("single_busy", busy, 0);
        check("single_pulls", n_pull - p0, 64);
        check_data("single_data", d0);

        // Backpressure on command and data
        p0 = n_pull; d0 = got_data.size(); a0 = got_addr.size();
        push_pkt(9); queue_expected(9);
        run_packet(5, 1, -1, -1, cyc);
        check("bp_stall", stall, 5);
        check("bp_cmds", got_addr.size() - a0, 1);
        check("bp_addr", got_addr[a0], 64);
        check("bp_pulls", n_pull - p0, 64);
        check("bp_no_pull_unready", bad_pull, 0);
        check("bp_wr_ptr", wr_ptr, 128);
        check_data("bp_data", d0);

        // Ring full: rd_ptr held at 0
        do_reset();
        a0 = got_addr.size();
        for (int p = 0; p < 3; p++) begin
            push_pkt(p * 3); run_packet(0, 0, -1, -1, cyc);
        end
        check("full_addr0", got_addr[a0], 0);
        check("full_addr1", got_addr[a0 + 1], 64);
        check("full_addr2", got_addr[a0 + 2], 128);
        check("full_no_ovf_yet", overflow, 0);
        p0 = n_pull; m0 = mem_act;
        push_pkt(50); run_packet(0, 0, -1, -1, cyc);
        check("full_drop_cycles", cyc, 65);
        check("full_overflow", overflow, 1);
        check("full_drop_count", drop_count, 1);
        check("full_wr_ptr", wr_ptr, 192);
        check("full_drop_pulls", n_pull - p0, 64);
        check("full_no_mem", mem_act - m0, 0);
        check("full_cmds", got_addr.size() - a0, 3);

        // Wrap: rd_ptr tracks wr_ptr so the ring is always empty
        do_reset();
        a0 = got_addr.size();
        for (int p = 0; p < 5; p++) begin
            rd_ptr = wr_ptr;
            push_pkt(p); run_packet(0, 0, -1, -1, cyc);
        end
        check("wrap_addr0", got_addr[a0], 0);
        check("wrap_addr1", got_addr[a0 + 1], 64);
        check("wrap_addr2", got_addr[a0 + 2], 128);
        check("wrap_addr3", got_addr[a0 + 3], 192);
        check("wrap_addr4", got_addr[a0 + 4], 0);
        check("wrap_wr_ptr", wr_ptr, 64);
        check("wrap_overflow", overflow, 0);

        // Enable gating and mid-packet enable drop / reset
        do_reset();
        rd_ptr = '0;
        enable = 1'b0;
        p0 = n_pull;
        push_pkt(7);
        repeat (10) @(posedge clk);
        #1;
        check("en_off_pulls", n_pull - p0, 0);
        check("en_off_busy", busy, 0);
        enable = 1'b1;
        d0 = got_data.size();
        queue_expected(7);
        run_packet(0, 0, 10, -1, cyc);
        check("en_drop_pulls", n_pull - p0, 64);
        check("en_drop_wr_ptr", wr_ptr, 64);
        check_data("en_drop_data", d0);
        enable = 1'b1;
        push_pkt(11);
        run_packet(0, 0, -1, 20, cyc);
        check("rst_mid_state", state_dbg, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pull", fifo_pull, 0);
        check("rst_mid_wr_valid", mem_wr_valid, 0);
        check("rst_mid_cmd_valid", mem_cmd_valid, 0);
        check("rst_mid_wr_ptr", wr_ptr, 0);
        check("rst_mid_drop", drop_count, 0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
